// File: rtl/axis_gmii_rx.sv
// GMII/MII receive framer to AXI-Stream.
// Strips preamble, SFD and FCS. Checks the FCS against the CRC-32 residue.
// Flags rx_er, runt and oversize frames on the final beat.
// There is no tready: each output byte is a single-cycle tvalid pulse.

module axis_gmii_rx #(
    parameter int MAX_FRAME_LENGTH = 1518
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] gmii_rxd,
    input  logic       gmii_rx_dv,
    input  logic       gmii_rx_er,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    output logic       m_axis_tlast,
    output logic       m_axis_tuser,
    input  logic       clk_enable,
    input  logic       mii_select,
    output logic       start_packet,
    output logic       error_bad_frame,
    output logic       error_bad_fcs
);

    localparam logic [7:0]  BYTE_PREAMBLE = 8'h55;
    localparam logic [7:0]  BYTE_SFD      = 8'hD5;
    localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY_REFL = 32'hEDB8_8320;  // 0x04C11DB7 bit-reversed
    localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB_20E3;
    localparam logic [2:0]  DLY_DEPTH     = 3'd5;            // one data byte plus four FCS bytes
    localparam logic [15:0] MAX_LEN       = 16'(MAX_FRAME_LENGTH);
    localparam logic [15:0] CNT_SAT       = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_PAYLOAD,
        ST_DROP
    } rx_state_t;

    // One reflected CRC-32 step over a whole byte, LSB first.
    function automatic logic [31:0] crc_next(input logic [31:0] crc_in, input logic [7:0] data);
        logic [31:0] c;
        c = crc_in ^ {24'h0, data};
        for (int k = 0; k < 8; k++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
        end
        return c;
    endfunction

    // Registered line inputs. Every later latency counts from this sample.
    logic [7:0]  rxd_q;
    logic        rx_dv_q;
    logic        rx_er_q;

    // MII nibble assembly.
    logic [3:0]  nib_lo;
    logic        nib_phase;     // 1: low nibble held, the next enabled cycle completes the byte

    // Framer state.
    rx_state_t   state;
    logic [31:0] crc;
    logic [15:0] byte_cnt;
    logic [2:0]  held_cnt;      // number of valid bytes in the delay line, 0..5
    logic        frame_err;
    logic [39:0] dly;           // [7:0] is the newest byte, [39:32] the oldest

    // Derived combinational terms.
    logic        byte_stb;      // a complete byte, or a dv=0 marker, is ready this cycle
    logic [7:0]  cur_byte;
    logic [31:0] crc_upd;
    logic [15:0] cnt_next;
    logic        dly_full;
    logic        fcs_bad;

    // Build the byte presented to the FSM and decide whether this cycle advances it.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
        byte_stb = 1'b0;
        cur_byte = rxd_q;
        if (clk_enable) begin
            if (!mii_select || !rx_dv_q) begin
                // A dv=0 cycle always counts as complete, so frame end is seen in either mode.
                byte_stb = 1'b1;
            end else if (nib_phase) begin
                byte_stb = 1'b1;
                cur_byte = {rxd_q[3:0], nib_lo};
            end
        end
    end

    assign crc_upd  = crc_next(crc, cur_byte);
    assign cnt_next = (byte_cnt == CNT_SAT) ? byte_cnt : byte_cnt + 16'd1;
    assign dly_full = (held_cnt == DLY_DEPTH);
    assign fcs_bad  = (crc != CRC_RESIDUE);

    // Capture the line and track the MII nibble phase. Both are frozen while clk_enable is low.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: registers are written with non-blocking assignments, so every block sees values from before the edge.
        if (!rst_n) begin
            rxd_q     <= 8'h00;
            rx_dv_q   <= 1'b0;
            rx_er_q   <= 1'b0;
            nib_lo    <= 4'h0;
            nib_phase <= 1'b0;
        end else if (clk_enable) begin
            rxd_q   <= gmii_rxd;
            rx_dv_q <= gmii_rx_dv;
            rx_er_q <= gmii_rx_er;
            if (!mii_select || !rx_dv_q) begin
                nib_phase <= 1'b0;
            end else begin
                nib_phase <= ~nib_phase;
                if (!nib_phase) begin
                    nib_lo <= rxd_q[3:0];
                end
            end
        end
    end

    // Five-byte delay line holding payload back until its tail is known to be FCS.
    always_ff @(posedge clk) begin
        // NOTE: pure data storage is left unreset; held_cnt says which entries are valid, so reset values would never be observed.
        if (byte_stb && rx_dv_q && (state == ST_PAYLOAD)) begin
            dly <= {dly[31:0], cur_byte};
        end
    end

    // Framing FSM with registered beat and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            crc             <= CRC_INIT;
            byte_cnt        <= 16'h0000;
            held_cnt        <= 3'd0;
            frame_err       <= 1'b0;
            m_axis_tdata    <= 8'h00;
            m_axis_tvalid   <= 1'b0;
            m_axis_tlast    <= 1'b0;
            m_axis_tuser    <= 1'b0;
            start_packet    <= 1'b0;
            error_bad_frame <= 1'b0;
            error_bad_fcs   <= 1'b0;
        end else begin
            // Beats and pulses last one cycle. They stay low on cycles that do not emit.
            m_axis_tdata    <= 8'h00;
            m_axis_tvalid   <= 1'b0;
            m_axis_tlast    <= 1'b0;
            m_axis_tuser    <= 1'b0;
            start_packet    <= 1'b0;
            error_bad_frame <= 1'b0;
            error_bad_fcs   <= 1'b0;

            // rx_er is checked on every enabled cycle, so an error on the MII low-nibble cycle is also caught.
            if (clk_enable && (state == ST_PAYLOAD) && rx_dv_q && rx_er_q) begin
                frame_err <= 1'b1;
            end

            if (byte_stb) begin
                unique case (state)
                    ST_IDLE: begin
                        if (rx_dv_q) begin
                            state <= (cur_byte == BYTE_PREAMBLE) ? ST_PREAMBLE : ST_DROP;
                        end
                    end

                    ST_PREAMBLE: begin
                        if (!rx_dv_q) begin
                            state <= ST_IDLE;
                        end else if (cur_byte == BYTE_SFD) begin
                            state        <= ST_PAYLOAD;
                            start_packet <= 1'b1;
                            crc          <= CRC_INIT;
                            byte_cnt     <= 16'h0000;
                            held_cnt     <= 3'd0;
                            frame_err    <= 1'b0;
                        end else if (cur_byte != BYTE_PREAMBLE) begin
                            state <= ST_DROP;
                        end
                    end

                    ST_PAYLOAD: begin
                        if (rx_dv_q) begin
                            crc      <= crc_upd;
                            byte_cnt <= cnt_next;
                            // An oversize frame is still received to the end; it is only flagged.
                            if (cnt_next > MAX_LEN) begin
                                frame_err <= 1'b1;
                            end
                            if (dly_full) begin
                                m_axis_tdata  <= dly[39:32];
                                m_axis_tvalid <= 1'b1;
                            end else begin
                                held_cnt <= held_cnt + 3'd1;
                            end
                        end else begin
                            state         <= ST_IDLE;
                            m_axis_tvalid <= 1'b1;
                            m_axis_tlast  <= 1'b1;
                            if (dly_full) begin
                                // The four bytes still held are the FCS and are discarded.
                                m_axis_tdata    <= dly[39:32];
                                m_axis_tuser    <= frame_err | fcs_bad;
                                error_bad_frame <= frame_err;
                                error_bad_fcs   <= fcs_bad;
                            end else begin
                                // Runt: close the stream with an empty, bad terminating beat.
                                m_axis_tdata    <= 8'h00;
                                m_axis_tuser    <= 1'b1;
                                error_bad_frame <= 1'b1;
                            end
                        end
                    end

                    ST_DROP: begin
                        if (!rx_dv_q) begin
                            state <= ST_IDLE;
                        end
                    end

                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_axis_gmii_rx.sv
// Scoreboard bench for axis_gmii_rx. Expected beats are queued as frames are driven.
// A negedge monitor pops and compares them.

module tb_axis_gmii_rx;

    typedef logic [7:0] byte_q_t [$];

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       user;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] gmii_rxd;
    logic       gmii_rx_dv;
    logic       gmii_rx_er;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tvalid;
    logic       m_axis_tlast;
    logic       m_axis_tuser;
    logic       clk_enable;
    logic       mii_select;
    logic       start_packet;
    logic       error_bad_frame;
    logic       error_bad_fcs;

    int    checks   = 0;
    int    failures = 0;
    int    sp_cnt   = 0;
    int    ebf_cnt  = 0;
    int    efcs_cnt = 0;
    bit    ce_toggle = 1'b0;
    logic  ce_at_edge = 1'b1;
    beat_t exp_q [$];

    axis_gmii_rx #(.MAX_FRAME_LENGTH(1518)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .gmii_rxd        (gmii_rxd),
        .gmii_rx_dv      (gmii_rx_dv),
        .gmii_rx_er      (gmii_rx_er),
        .m_axis_tdata    (m_axis_tdata),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tlast    (m_axis_tlast),
        .m_axis_tuser    (m_axis_tuser),
        .clk_enable      (clk_enable),
        .mii_select      (mii_select),
        .start_packet    (start_packet),
        .error_bad_frame (error_bad_frame),
        .error_bad_fcs   (error_bad_fcs)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ce_at_edge = clk_enable;

    // Scoreboard monitor: compare each beat and count status pulses.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (m_axis_tvalid) begin
                beat_t e;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_beat: got data=%02h last=%0b user=%0b, expected no beat",
                             m_axis_tdata, m_axis_tlast, m_axis_tuser);
                end else begin
                    e = exp_q.pop_front();
                    if ({m_axis_tdata, m_axis_tlast, m_axis_tuser} !== {e.data, e.last, e.user}) begin
                        failures++;
                        $display("FAIL beat: got data=%02h last=%0b user=%0b, expected data=%02h last=%0b user=%0b",
                                 m_axis_tdata, m_axis_tlast, m_axis_tuser, e.data, e.last, e.user);
                    end
                end
            end
            if (!ce_at_edge) begin
                checks++;
                if ({m_axis_tvalid, m_axis_tlast, m_axis_tuser, start_packet, error_bad_frame, error_bad_fcs} !== 6'b0) begin
                    failures++;
                    $display("FAIL outputs_while_disabled: got %06b expected 000000",
                             {m_axis_tvalid, m_axis_tlast, m_axis_tuser, start_packet, error_bad_frame, error_bad_fcs});
                end
            end
            if (start_packet)    sp_cnt++;
            if (error_bad_frame) ebf_cnt++;
            if (error_bad_fcs)   efcs_cnt++;
        end
    end

    // Ethernet FCS of a payload: reflected CRC-32, final complement.
    function automatic logic [31:0] fcs_of(input byte_q_t p);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        foreach (p[i]) begin
            c = c ^ {24'h0, p[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return ~c;
    endfunction

    function automatic byte_q_t ramp(input int n);
        byte_q_t q;
        for (int i = 0; i < n; i++) q.push_back(8'(i));
        return q;
    endfunction

    // Full on-wire frame: preamble, SFD, payload, FCS LSB first, with optional FCS corruption.
    function automatic byte_q_t wire_of(input byte_q_t p, input bit bad_fcs);
        byte_q_t     w;
        logic [31:0] f;
        logic [7:0]  b;
        f = fcs_of(p);
        for (int i = 0; i < 7; i++) w.push_back(8'h55);
        w.push_back(8'hD5);
        foreach (p[i]) w.push_back(p[i]);
        for (int k = 0; k < 4; k++) begin
            b = f[8*k +: 8];
            if (k == 0 && bad_fcs) b = b ^ 8'h01;
            w.push_back(b);
        end
        return w;
    endfunction

    task automatic push_expected(input byte_q_t p, input bit user);
        foreach (p[i]) begin
            exp_q.push_back(beat_t'{data: p[i], last: (i == p.size() - 1), user: (i == p.size() - 1) && user});
        end
    endtask

    task automatic drive_cycle(input logic [7:0] d, input logic dv, input logic er);
        @(posedge clk); #1;
        gmii_rxd   = d;
        gmii_rx_dv = dv;
        gmii_rx_er = er;
        clk_enable = 1'b1;
        if (ce_toggle) begin
            @(posedge clk); #1;
            clk_enable = 1'b0;
        end
    endtask

    // In MII mode the unused upper nibble carries junk, which the DUT must ignore.
    task automatic drive_byte(input logic [7:0] b, input logic er);
        if (mii_select) begin
            drive_cycle({~b[3:0], b[3:0]}, 1'b1, er);
            drive_cycle({~b[7:4], b[7:4]}, 1'b1, er);
        end else begin
            drive_cycle(b, 1'b1, er);
        end
    endtask

    task automatic drive_idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(8'h00, 1'b0, 1'b0);
    endtask

    task automatic send_wire(input byte_q_t w, input int er_wire_idx);
        foreach (w[i]) drive_byte(w[i], i == er_wire_idx);
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_drained: got %0d beats outstanding, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; gmii_rxd = 8'h00; gmii_rx_dv = 1'b0; gmii_rx_er = 1'b0;
        clk_enable = 1'b1; mii_select = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser, start_packet, error_bad_frame, error_bad_fcs} !== 14'b0) begin
            failures++;
            $display("FAIL reset_outputs: got tdata=%02h flags=%06b, expected all zero", m_axis_tdata,
                     {m_axis_tvalid, m_axis_tlast, m_axis_tuser, start_packet, error_bad_frame, error_bad_fcs});
        end
        rst_n = 1'b1;
        drive_idle(4);
        checks++;
        if ({m_axis_tvalid, start_packet, error_bad_frame, error_bad_fcs} !== 4'b0) begin
            failures++;
            $display("FAIL idle_outputs: got %04b expected 0000", {m_axis_tvalid, start_packet, error_bad_frame, error_bad_fcs});
        end
    endtask

    task automatic test_frame(input string name, input byte_q_t p, input bit bad_fcs, input int er_idx,
                              input bit exp_user, input int exp_ebf, input int exp_efcs);
        int sp0, ebf0, efcs0;
        sp0 = sp_cnt; ebf0 = ebf_cnt; efcs0 = efcs_cnt;
        push_expected(p, exp_user);
        send_wire(wire_of(p, bad_fcs), (er_idx < 0) ? -1 : er_idx + 8);
        drive_idle(16);
        check_drained(name);
        checks++;
        if (sp_cnt - sp0 !== 1) begin
            failures++;
            $display("FAIL %s_start_packet: got %0d pulses expected 1", name, sp_cnt - sp0);
        end
        checks++;
        if (ebf_cnt - ebf0 !== exp_ebf) begin
            failures++;
            $display("FAIL %s_bad_frame: got %0d pulses expected %0d", name, ebf_cnt - ebf0, exp_ebf);
        end
        checks++;
        if (efcs_cnt - efcs0 !== exp_efcs) begin
            failures++;
            $display("FAIL %s_bad_fcs: got %0d pulses expected %0d", name, efcs_cnt - efcs0, exp_efcs);
        end
    endtask

    task automatic test_runt;
        int ebf0, efcs0;
        ebf0 = ebf_cnt; efcs0 = efcs_cnt;
        exp_q.push_back(beat_t'{data: 8'h00, last: 1'b1, user: 1'b1});
        for (int i = 0; i < 7; i++) drive_byte(8'h55, 1'b0);
        drive_byte(8'hD5, 1'b0);
        for (int i = 0; i < 3; i++) drive_byte(8'hA0 + 8'(i), 1'b0);
        drive_idle(16);
        check_drained("runt");
        checks++;
        if (ebf_cnt - ebf0 !== 1 || efcs_cnt - efcs0 !== 0) begin
            failures++;
            $display("FAIL runt_pulses: got bad_frame=%0d bad_fcs=%0d expected 1 and 0", ebf_cnt - ebf0, efcs_cnt - efcs0);
        end
    endtask

    task automatic test_back_to_back;
        byte_q_t a, b;
        int sp0;
        sp0 = sp_cnt;
        a = ramp(20);
        b = ramp(33);
        push_expected(a, 1'b0);
        push_expected(b, 1'b0);
        send_wire(wire_of(a, 1'b0), -1);
        drive_idle(1);
        send_wire(wire_of(b, 1'b0), -1);
        drive_idle(16);
        check_drained("back_to_back");
        checks++;
        if (sp_cnt - sp0 !== 2) begin
            failures++;
            $display("FAIL back_to_back_start_packet: got %0d pulses expected 2", sp_cnt - sp0);
        end
    endtask

    task automatic test_mii;
        ce_toggle  = 1'b1;
        mii_select = 1'b1;
        test_frame("mii", ramp(64), 1'b0, -1, 1'b0, 0, 0);
        ce_toggle  = 1'b0;
        mii_select = 1'b0;
        drive_idle(4);
    endtask

    task automatic test_reset_mid_frame;
        byte_q_t p, w;
        int sp0;
        p = ramp(60);
        w = wire_of(p, 1'b0);
        push_expected(p, 1'b0);
        foreach (w[i]) begin
            drive_byte(w[i], 1'b0);
            if (i == 28) begin
                #2 rst_n = 1'b0;
                #1;
                checks++;
                if ({m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser, start_packet, error_bad_frame, error_bad_fcs} !== 14'b0) begin
                    failures++;
                    $display("FAIL mid_reset_outputs: got tdata=%02h valid=%0b, expected all zero", m_axis_tdata, m_axis_tvalid);
                end
                exp_q.delete();
            end
            if (i == 30) #2 rst_n = 1'b1;
        end
        sp0 = sp_cnt;
        drive_idle(16);
        check_drained("mid_reset_drop");
        checks++;
        if (sp_cnt - sp0 !== 0) begin
            failures++;
            $display("FAIL mid_reset_start_packet: got %0d pulses expected 0", sp_cnt - sp0);
        end
        test_frame("after_reset", ramp(60), 1'b0, -1, 1'b0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_frame("good", ramp(60), 1'b0, -1, 1'b0, 0, 0);
        test_frame("fcs_err", ramp(60), 1'b1, -1, 1'b1, 0, 1);
        test_frame("rx_er", ramp(60), 1'b0, 10, 1'b1, 1, 0);
        test_runt();
        test_back_to_back();
        test_frame("max_len", ramp(1514), 1'b0, -1, 1'b0, 0, 0);
        test_frame("oversize", ramp(1516), 1'b0, -1, 1'b1, 1, 0);
        test_frame("both_err", ramp(60), 1'b1, 5, 1'b1, 1, 1);
        test_mii();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/axis_gmii_rx.md
AXIS_GMII_RX -- requirements
Module: axis_gmii_rx

Interface
REQ-001 SHALL have parameter MAX_FRAME_LENGTH, default 1518, meaning the maximum number of bytes after the SFD, FCS included.
REQ-002 SHALL have a single clock and an asynchronous, active-low reset; ports listed below, clock and reset first.
REQ-003 clk  in  1  sole clock; all logic on the rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 gmii_rxd  in  8  receive data; MII mode uses [3:0] only.
REQ-006 gmii_rx_dv  in  1  receive data valid.
REQ-007 gmii_rx_er  in  1  receive error.
REQ-008 m_axis_tdata  out  8  frame byte, preamble, SFD and FCS stripped.
REQ-009 m_axis_tvalid  out  1  byte valid; single-cycle pulse per byte; no tready, so no backpressure.
REQ-010 m_axis_tlast  out  1  last byte of frame.
REQ-011 m_axis_tuser  out  1  bad frame; valid only with tlast.
REQ-012 clk_enable  in  1  low: hold all state, emit no beats.
REQ-013 mii_select  in  1  high: 4-bit MII nibble mode.
REQ-014 start_packet  out  1  one-cycle pulse on SFD detect.
REQ-015 error_bad_frame  out  1  one-cycle pulse on rx_er, runt, or oversize frame.
REQ-016 error_bad_fcs  out  1  one-cycle pulse on FCS mismatch.

Function
REQ-017 SHALL register gmii_rxd, gmii_rx_dv and gmii_rx_er once on input; all following latencies count from this registered sample.
REQ-018 In MII mode, SHALL assemble bytes from two enabled cycles, low nibble first; the byte is processed on the high-nibble cycle; the nibble phase resets whenever rx_dv is low.
REQ-019 SHALL implement states IDLE, PREAMBLE, PAYLOAD and DROP; only cycles with clk_enable high and a complete byte advance the FSM.
REQ-020 IDLE: dv=1 and byte 0x55 -> PREAMBLE; dv=1 and any other byte -> DROP.
REQ-021 PREAMBLE: byte 0x55 -> stay; byte 0xD5 -> PAYLOAD, pulse start_packet, reset CRC to 0xFFFFFFFF and byte count to 0; any other byte or dv=0 -> DROP (or IDLE if dv=0).
REQ-022 DROP: wait for dv=0, then -> IDLE; no output beats.
REQ-023 PAYLOAD: each byte SHALL update the CRC-32 (poly 0x04C11DB7, reflected, Galois, 8 bits/step) and shift into a 5-byte delay line; count saturates at 0xFFFF.
REQ-024 When a byte arrives with 5 bytes already held, SHALL emit the oldest byte next cycle with tvalid=1, tlast=0, tuser=0.
REQ-025 On dv=0 in PAYLOAD with 5 bytes held, SHALL emit the oldest byte next cycle with tvalid=1 and tlast=1; the 4 remaining bytes are the FCS and SHALL be discarded; then -> IDLE.
REQ-026 FCS check: the CRC register over payload plus FCS SHALL equal 0xDEBB20E3; otherwise set tuser=1 on tlast and pulse error_bad_fcs in the same cycle.
REQ-027 rx_er=1 with dv=1 anywhere in PAYLOAD SHALL latch an error flag; at end of frame, tuser=1 and pulse error_bad_frame.
REQ-028 Count > MAX_FRAME_LENGTH SHALL set the error flag (tuser=1, error_bad_frame) but reception SHALL continue until dv=0.
REQ-029 Runt (dv=0 with fewer than 5 bytes held) SHALL emit one beat tdata=0x00, tvalid=1, tlast=1, tuser=1, and pulse error_bad_frame.
REQ-030 When FCS and frame errors occur together, SHALL pulse both error outputs and give one tuser=1.
REQ-031 clk_enable low SHALL freeze the FSM, CRC, delay line and nibble phase; beat and status outputs SHALL be 0.
REQ-032 SFD bytes are never output.
REQ-033 Interframe gap SHALL NOT be enforced; a new preamble is accepted one byte after dv=0.

Reset
REQ-034 rst_n low SHALL asynchronously force the state to IDLE, CRC to 0xFFFFFFFF, the count and nibble phase to 0, the error flag to 0, and all outputs to 0.
REQ-035 Release mid-frame, with dv=1 and a non-0x55 byte, SHALL go to DROP; no beats are emitted until a fresh preamble arrives.

Verification
REQ-036 GMII frame: 7x0x55, 0xD5, 60 bytes 0x00..0x3B, correct FCS -> 60 beats in order, tlast on 0x3B, tuser=0, one start_packet, no error pulses.
REQ-037 Same frame with FCS byte 0 XOR 0x01 -> 60 beats, tuser=1 on tlast, error_bad_fcs pulses once.
REQ-038 rx_er=1 for one cycle at payload byte 10 -> 60 beats, tuser=1, error_bad_frame pulses once.
REQ-039 Runt: SFD, 3 bytes, then dv=0 -> one beat tdata=0x00, tlast=1, tuser=1, error_bad_frame pulses.
REQ-040 MII mode with clk_enable toggling every other cycle, 64-byte frame -> byte stream identical to the GMII case and FCS good.
REQ-041 rst_n pulsed low at payload byte 20 -> outputs 0 immediately; remaining bytes dropped; the next full frame is received correctly.
